// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } pipe_state_t;

  localparam int unsigned SLOT_NOP = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on reset only.
module pipe_sat_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [COUNT_W-1:0] cnt
);

  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble/flush saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SLOTS = 3,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(SLOT_NOP)
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned       COUNT_W   = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SLOTS*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_SLOTS*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [COUNT_W-1:0]          stall_cnt,
  output logic [COUNT_W-1:0]          bubble_cnt,
  output logic [COUNT_W-1:0]          flush_cnt
`endif
);

  localparam int unsigned             ENTRY_W   = NUM_SLOTS * DATA_W;
  localparam logic [ENTRY_W-1:0]      NOP_ENTRY = {NUM_SLOTS{NOP_VALUE}};

  pipe_state_t        state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : NOP_ENTRY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_ENTRY;
      skid_d  = NOP_ENTRY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is derived from the next state so it can be presented straight from a flop.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= NOP_ENTRY;
      skid_q     <= NOP_ENTRY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.COUNT_W(COUNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );

  pipe_sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by random traffic.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned EW = DW * NS;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, bubble_cnt, flush_cnt;
  int unsigned   m_stall, m_bubble, m_flush;
`endif

  int unsigned   n_checks;
  int unsigned   n_fail;

  // Reference model: an ordered list of accepted entries, capacity two.
  logic [EW-1:0] exp_q[$];
  int unsigned   occ;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .NUM_SLOTS (NS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update on each accepted clock edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      occ = 0;
      exp_q.delete();
`ifdef PIPE_STAGE_PERF_EN
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
    end else begin
      automatic bit take = in_valid && (occ < 2);
      automatic bit give = (occ > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
      if (occ > 0 && !out_ready) m_stall++;
      if (occ == 0) m_bubble++;
      if (flush) m_flush++;
`endif
      if (flush) begin
        occ = 0;
        exp_q.delete();
      end else begin
        occ = occ + (take ? 1 : 0) - (give ? 1 : 0);
        if (take) exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head entry on a handshake.
  always @(negedge clk) begin
    chk("in_ready", EW'(in_ready), EW'(occ < 2));
    chk("out_valid", EW'(out_valid), EW'(occ > 0));
    if (occ == 0) begin
      chk("nop_data", out_data, '0);
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_empty", EW'(exp_q.size()), EW'(occ));
    end else begin
      chk("out_data", out_data, exp_q[0]);
      if (out_valid && out_ready && !reset) void'(exp_q.pop_front());
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", EW'(stall_cnt), EW'(m_stall));
    chk("bubble_cnt", EW'(bubble_cnt), EW'(m_bubble));
    chk("flush_cnt", EW'(flush_cnt), EW'(m_flush));
`endif
  end

  task automatic cyc(input logic v, input logic [EW-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] tag(input int unsigned t);
    return {DW'(t), DW'(t + 100), DW'(t + 200)};
  endfunction

  function automatic logic [EW-1:0] rnd_entry();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, '0, 1, 0);

    // Streaming A,B,C with consumer always ready.
    for (int unsigned i = 1; i <= 3; i++) cyc(1, tag(i), 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // Back-pressure: A,B fill the stage, C held by producer, then drain.
    cyc(1, tag(11), 0, 0);
    cyc(1, tag(12), 0, 0);
    for (int unsigned i = 0; i < 3; i++) cyc(1, tag(13), 0, 0);
    cyc(1, tag(13), 1, 0);
    for (int unsigned i = 0; i < 4; i++) cyc(0, '0, 1, 0);

    // Flush while full with a new entry offered: it must vanish.
    cyc(1, tag(21), 0, 0);
    cyc(1, tag(22), 0, 0);
    cyc(1, tag(23), 0, 1);
    cyc(0, '0, 1, 0);

    // Flush coinciding with consumption of a single held entry.
    cyc(1, tag(31), 0, 0);
    cyc(0, '0, 1, 1);
    cyc(0, '0, 1, 0);

    // Asynchronous reset while full, asserted between clock edges.
    cyc(1, tag(41), 0, 0);
    cyc(1, tag(42), 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_in_ready", EW'(in_ready), EW'(1));
    chk("async_out_valid", EW'(out_valid), EW'(0));
    chk("async_out_data", out_data, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, tag(51), 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // Random traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), rnd_entry(), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 29) == 0));
    end
    for (int unsigned i = 0; i < 4; i++) cyc(0, '0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
